mips_div_seq: RTL and testbench



---
 rtl/mips_div_pkg.sv | 14 +
 rtl/div_step.sv | 24 ++
 rtl/mips_div_seq.sv | 132 +++++++++++++
 tb/tb_mips_div_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_div_pkg.sv
// Shared constants for the sequential MIPS DIV/DIVU unit: default sizes,
// iteration counter width and FSM state encodings.
package mips_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITER);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it did not go negative.
module div_step
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor always holds, so bit WIDTH of diff is a clean borrow flag.
  assign shifted  = {rem, bit_in};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mips_div_seq.sv
// Sequential MIPS DIV/DIVU: magnitude restoring division, one quotient bit
// per clock, with sign fix-up and N/Z/V/DZ flags produced in a final cycle.
module mips_div_seq
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITER  = DIV_ITER
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] Y_hi,
  output logic [WIDTH-1:0] Y_lo,
  output logic             busy,
  output logic             done,
  output logic             N,
  output logic             Z,
  output logic             V,
  output logic             DZ
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] s_raw_reg;
  logic             q_neg_reg;
  logic             r_neg_reg;
  logic             ovf_reg;
  logic             dz_reg;

  logic [WIDTH-1:0] abs_s;
  logic [WIDTH-1:0] abs_t;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] lo_fix;
  logic [WIDTH-1:0] hi_fix;

  assign abs_s = (sign && S[WIDTH-1]) ? -S : S;
  assign abs_t = (sign && T[WIDTH-1]) ? -T : T;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .bit_in   (quo_reg[WIDTH-1]),
    .divisor  (dvs_reg),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Divide-by-zero results are formed in FIX like every other result.
  always_comb begin
    lo_fix = q_neg_reg ? -quo_reg : quo_reg;
    hi_fix = r_neg_reg ? -rem_reg : rem_reg;
    if (dz_reg) begin
      lo_fix = '1;
      hi_fix = s_raw_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvs_reg   <= '0;
      s_raw_reg <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      dz_reg    <= 1'b0;
      Y_hi      <= '0;
      Y_lo      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      N         <= 1'b0;
      Z         <= 1'b1;
      V         <= 1'b0;
      DZ        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            s_raw_reg <= S;
            quo_reg   <= abs_s;
            rem_reg   <= '0;
            dvs_reg   <= abs_t;
            q_neg_reg <= sign && (S[WIDTH-1] ^ T[WIDTH-1]);
            r_neg_reg <= sign && S[WIDTH-1];
            ovf_reg   <= sign && (S == MIN_NEG) && (T == '1);
            dz_reg    <= (T == '0);
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= (T == '0) ? ST_FIX : ST_RUN;
          end
        end
        ST_RUN: begin
          // Dividend bits leave quo_reg at the top as quotient bits enter at the bottom.
          quo_reg <= {quo_reg[WIDTH-2:0], q_bit};
          rem_reg <= rem_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(ITER - 1)) begin
            state_reg <= ST_FIX;
          end
        end
        ST_FIX: begin
          Y_lo      <= lo_fix;
          Y_hi      <= hi_fix;
          N         <= lo_fix[WIDTH-1];
          Z         <= (lo_fix == '0);
          V         <= ovf_reg && !dz_reg;
          DZ        <= dz_reg;
          done      <= 1'b1;
          state_reg <= ST_DONE;
        end
        default: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_seq.sv
// Self-checking bench for mips_div_seq: vector table plus hand-written
// sequences for start-while-busy and mid-operation reset.
module tb_mips_div_seq;

  typedef struct {
    logic        sgn;
    logic [31:0] s;
    logic [31:0] t;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        n;
    logic        z;
    logic        v;
    logic        dz;
    int          lat;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        sign;
  logic [31:0] S;
  logic [31:0] T;
  logic [31:0] Y_hi;
  logic [31:0] Y_lo;
  logic        busy;
  logic        done;
  logic        N;
  logic        Z;
  logic        V;
  logic        DZ;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t sb[$];
  vec_t vecs[$];

  mips_div_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .sign    (sign),
    .S       (S),
    .T       (T),
    .Y_hi    (Y_hi),
    .Y_lo    (Y_lo),
    .busy    (busy),
    .done    (done),
    .N       (N),
    .Z       (Z),
    .V       (V),
    .DZ      (DZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Waits for done, checks latency, then pops the scoreboard and compares.
  task automatic wait_check(input int exp_lat, input string tag);
    int   lat;
    vec_t e;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (lat != 0) begin
      chk({tag, "_Y_lo"}, Y_lo, e.lo);
      chk({tag, "_Y_hi"}, Y_hi, e.hi);
      chk({tag, "_NZVDZ"}, {28'd0, N, Z, V, DZ}, {28'd0, e.n, e.z, e.v, e.dz});
      @(posedge clk);
      #1;
      chk({tag, "_done_busy_after"}, {30'd0, done, busy}, 32'd0);
    end
    $display("vec %s sgn=%0d S=%h T=%h -> lo=%h hi=%h NZVDZ=%b%b%b%b lat=%0d",
             tag, e.sgn, e.s, e.t, Y_lo, Y_hi, N, Z, V, DZ, lat);
  endtask

  task automatic issue(input vec_t v);
    @(negedge clk);
    start = 1'b1;
    sign  = v.sgn;
    S     = v.s;
    T     = v.t;
    sb.push_back(v);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  function automatic vec_t mk(input logic sg, input logic [31:0] s, input logic [31:0] t,
                              input logic [31:0] lo, input logic [31:0] hi,
                              input logic v, input logic dz, input int lat);
    vec_t r;
    r.sgn = sg; r.s = s; r.t = t; r.lo = lo; r.hi = hi;
    r.n = lo[31]; r.z = (lo == 32'd0); r.v = v; r.dz = dz; r.lat = lat;
    return r;
  endfunction

  initial begin
    int          cnt_done;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] q;
    logic [31:0] r;
    start   = 1'b0;
    sign    = 1'b0;
    S       = '0;
    T       = '0;
    reset_n = 1'b0;

    vecs.push_back(mk(1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 33));
    vecs.push_back(mk(1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 1'b0, 33));
    vecs.push_back(mk(1'b0, 32'h00001234,   32'd0,          32'hFFFFFFFF,   32'h00001234,   1'b0, 1'b1, 1));
    vecs.push_back(mk(1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b1, 1'b0, 33));
    vecs.push_back(mk(1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 1'b0, 33));
    vecs.push_back(mk(1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 1'b0, 33));
    vecs.push_back(mk(1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 1'b0, 33));
    vecs.push_back(mk(1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD,   32'd2,          32'hFFFFFFFE,   1'b0, 1'b0, 33));
    vecs.push_back(mk(1'b1, 32'hFFFFFFF0,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF0,   1'b0, 1'b1, 1));
    vecs.push_back(mk(1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 1'b0, 33));
    for (int i = 0; i < 4; i++) begin
      rs = $urandom;
      rt = $urandom_range(1, 70000);
      q  = rs / rt;
      r  = rs % rt;
      vecs.push_back(mk(1'b0, rs, rt, q, r, 1'b0, 1'b0, 33));
    end
    for (int i = 0; i < 4; i++) begin
      rs = $urandom_range(0, 1000000);
      rt = $urandom_range(1, 900);
      if (i[0]) rs = -rs;
      if (i[1]) rt = -rt;
      q  = $signed(rs) / $signed(rt);
      r  = $signed(rs) % $signed(rt);
      vecs.push_back(mk(1'b1, rs, rt, q, r, 1'b0, 1'b0, 33));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {Y_lo ^ Y_hi, 28'd0} , 32'd0);
    chk("reset_flags", {26'd0, busy, done, N, Z, V, DZ}, 32'b000100);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i]);
      wait_check(vecs[i].lat, $sformatf("tbl%0d", i));
    end

    // start pulsed while busy must be ignored
    issue(mk(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0, 33));
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    S     = 32'd55;
    T     = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_during_run", {31'd0, busy}, 32'd1);
    wait_check(23, "busy_start");
    cnt_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt_done++;
    end
    chk("busy_start_extra_done", 32'(cnt_done), 32'd0);

    // reset mid-operation aborts with no done pulse
    issue(mk(1'b0, 32'd123456, 32'd7, 32'd17636, 32'd4, 1'b0, 1'b0, 33));
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
    chk("abort_Y_lo", Y_lo, 32'd0);
    chk("abort_Y_hi", Y_hi, 32'd0);
    chk("abort_flags", {28'd0, N, Z, V, DZ}, 32'b0100);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) cnt_done++;
    end
    chk("abort_no_done", 32'(cnt_done), 32'd0);
    issue(mk(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 33));
    wait_check(33, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
